// File: rtl/mem_port_arbiter_if.sv
// Bundle between fetch, load/store queue, arbiter and memory port.
// The arbiter takes the slave view; the environment takes the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MBE_W = DATA_W / 8;

    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [MBE_W-1:0]  d_mbe;
    logic [DATA_W-1:0] d_rdata;
    logic              d_resp;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MBE_W-1:0]  mem_mbe;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_read, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_addr, d_wdata, d_mbe,
        output d_rdata, d_resp,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_mbe,
        input  mem_rdata, mem_resp
    );

    modport master (
        output i_read, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_addr, d_wdata, d_mbe,
        input  d_rdata, d_resp,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_mbe,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and the load/store queue,
// round-robin on ties, one outstanding transaction at a time.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int MBE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state_q;
    logic              last_q;
    logic              rd_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MBE_W-1:0]  mbe_q;

    logic i_req;
    logic d_req;
    logic pick_d;

    assign i_req  = bus.i_read;
    assign d_req  = bus.d_read | bus.d_write;
    // On a tie the side that did not win last time gets the port.
    assign pick_d = d_req & (~i_req | ~last_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mbe_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q <= SERVE_D;
                        last_q  <= 1'b1;
                        rd_q    <= bus.d_read & ~bus.d_write;
                        wr_q    <= bus.d_write;
                        addr_q  <= bus.d_addr;
                        wdata_q <= bus.d_wdata;
                        mbe_q   <= bus.d_mbe;
                    end else if (i_req) begin
                        state_q <= SERVE_I;
                        last_q  <= 1'b0;
                        rd_q    <= 1'b1;
                        wr_q    <= 1'b0;
                        addr_q  <= bus.i_addr;
                        wdata_q <= '0;
                        mbe_q   <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (bus.mem_resp) begin
                        state_q <= IDLE;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_read  = rd_q;
    assign bus.mem_write = wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_mbe   = mbe_q;

    assign bus.i_resp  = (state_q == SERVE_I) & bus.mem_resp;
    assign bus.d_resp  = (state_q == SERVE_D) & bus.mem_resp;
    assign bus.i_rdata = bus.i_resp ? bus.mem_rdata : '0;
    assign bus.d_rdata = bus.d_resp ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Inputs change 1ns after each rising edge; checks run 1ns after that.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_read    = 1'b0;
        bus.i_addr    = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_mbe     = '0;
        bus.mem_rdata = '0;
        bus.mem_resp  = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_read"}, 64'(bus.mem_read), 64'd0);
        chk({tag, "_mem_write"}, 64'(bus.mem_write), 64'd0);
        chk({tag, "_i_resp"}, 64'(bus.i_resp), 64'd0);
        chk({tag, "_d_resp"}, 64'(bus.d_resp), 64'd0);
        chk({tag, "_i_rdata"}, 64'(bus.i_rdata), 64'd0);
        chk({tag, "_d_rdata"}, 64'(bus.d_rdata), 64'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        #1;
        chk_quiet("rst");
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_mem_mbe", 64'(bus.mem_mbe), 64'd0);
        rst = 1'b0;
        tick();

        // fetch only
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_0040;
        #1;
        chk("f0_mem_read", 64'(bus.mem_read), 64'd0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            #1;
            chk("f_mem_read", 64'(bus.mem_read), 64'd1);
            chk("f_mem_addr", 64'(bus.mem_addr), 64'h40);
            chk("f_i_resp", 64'(bus.i_resp), 64'd0);
        end
        tick();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h0000_0013;
        #1;
        chk("f4_mem_read", 64'(bus.mem_read), 64'd1);
        chk("f4_i_resp", 64'(bus.i_resp), 64'd1);
        chk("f4_i_rdata", 64'(bus.i_rdata), 64'h13);
        chk("f4_d_resp", 64'(bus.d_resp), 64'd0);
        chk("f4_d_rdata", 64'(bus.d_rdata), 64'd0);
        tick();
        idle_inputs();
        #1;
        chk_quiet("f5");

        // store, address changes after grant
        tick();
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h1000_0004;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_mbe   = 4'b0011;
        tick();
        bus.d_addr = 32'hFFFF_FFFF;
        #1;
        chk("s1_mem_write", 64'(bus.mem_write), 64'd1);
        chk("s1_mem_read", 64'(bus.mem_read), 64'd0);
        chk("s1_mem_addr", 64'(bus.mem_addr), 64'h1000_0004);
        chk("s1_mem_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
        chk("s1_mem_mbe", 64'(bus.mem_mbe), 64'b0011);
        tick();
        #1;
        chk("s2_mem_addr", 64'(bus.mem_addr), 64'h1000_0004);
        chk("s2_mem_read", 64'(bus.mem_read), 64'd0);
        chk("s2_d_resp", 64'(bus.d_resp), 64'd0);
        tick();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'hAAAA_5555;
        #1;
        chk("s3_d_resp", 64'(bus.d_resp), 64'd1);
        chk("s3_d_rdata", 64'(bus.d_rdata), 64'hAAAA_5555);
        chk("s3_i_resp", 64'(bus.i_resp), 64'd0);
        tick();
        idle_inputs();
        #1;
        chk_quiet("s4");

        // tie after reset: D first, I after a bubble
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_read = 1'b1;
        bus.i_addr = 32'h0000_0100;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_0200;
        tick();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h11;
        #1;
        chk("t1_mem_addr", 64'(bus.mem_addr), 64'h200);
        chk("t1_d_resp", 64'(bus.d_resp), 64'd1);
        chk("t1_d_rdata", 64'(bus.d_rdata), 64'h11);
        chk("t1_i_resp", 64'(bus.i_resp), 64'd0);
        tick();
        bus.d_read   = 1'b0;
        bus.mem_resp = 1'b0;
        #1;
        chk("t2_bubble", 64'(bus.mem_read), 64'd0);
        tick();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h22;
        #1;
        chk("t3_mem_read", 64'(bus.mem_read), 64'd1);
        chk("t3_mem_addr", 64'(bus.mem_addr), 64'h100);
        chk("t3_i_resp", 64'(bus.i_resp), 64'd1);
        chk("t3_i_rdata", 64'(bus.i_rdata), 64'h22);
        tick();
        bus.i_read   = 1'b0;
        bus.mem_resp = 1'b0;

        // starvation: both held, grants alternate D I D I
        tick();
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = 32'h500 + 32'(k);
            #1;
            chk("rr_mem_read", 64'(bus.mem_read), 64'd1);
            chk("rr_mem_addr", 64'(bus.mem_addr),
                (k % 2 == 0) ? 64'h200 : 64'h100);
            chk("rr_d_resp", 64'(bus.d_resp),
                (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_i_resp", 64'(bus.i_resp),
                (k % 2 == 0) ? 64'd0 : 64'd1);
            tick();
            bus.mem_resp = 1'b0;
            #1;
            chk("rr_bubble", 64'(bus.mem_read), 64'd0);
        end
        idle_inputs();

        // reset two cycles into SERVE_D
        tick();
        bus.d_read = 1'b1;
        bus.d_addr = 32'h0000_0300;
        tick();
        #1;
        chk("r1_mem_read", 64'(bus.mem_read), 64'd1);
        tick();
        rst = 1'b1;
        bus.d_read = 1'b0;
        tick();
        rst = 1'b0;
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h77;
        #1;
        chk_quiet("r3");
        chk("r3_mem_addr", 64'(bus.mem_addr), 64'd0);

        // spurious response in IDLE
        tick();
        bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk_quiet("sp");
        tick();
        bus.mem_resp = 1'b0;
        bus.i_read   = 1'b1;
        bus.i_addr   = 32'h0000_0080;
        #1;
        chk("sp_still_idle", 64'(bus.mem_read), 64'd0);

        // minimum latency: memory answers in first request cycle
        tick();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h0000_00AB;
        #1;
        chk("ml_mem_read", 64'(bus.mem_read), 64'd1);
        chk("ml_mem_addr", 64'(bus.mem_addr), 64'h80);
        chk("ml_i_resp", 64'(bus.i_resp), 64'd1);
        chk("ml_i_rdata", 64'(bus.i_rdata), 64'hAB);
        tick();
        idle_inputs();

        // illegal read+write: write wins
        tick();
        bus.d_read  = 1'b1;
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h0000_0400;
        bus.d_wdata = 32'h1234_5678;
        bus.d_mbe   = 4'b1111;
        tick();
        #1;
        chk("rw_mem_write", 64'(bus.mem_write), 64'd1);
        chk("rw_mem_read", 64'(bus.mem_read), 64'd0);
        chk("rw_mem_mbe", 64'(bus.mem_mbe), 64'hF);
        bus.mem_resp = 1'b1;
        #1;
        chk("rw_d_resp", 64'(bus.d_resp), 64'd1);
        tick();
        idle_inputs();
        #1;
        chk_quiet("end");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
